// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
//   Shared definitions for the multi-cycle MIPS main control FSM:
//   state encodings, opcode constants, aluop / alu_src_b / pc_source codes,
//   and the packed control word produced by the state decoder.
package mc_ctrl_pkg;

   localparam int OPW = 6;
   localparam int STW = 4;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEM_ADDR = 4'd3,
      S_MEM_RD   = 4'd4,
      S_MEM_WB   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_EXEC     = 4'd7,
      S_R_WB     = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_ADDI_EX  = 4'd11,
      S_ADDI_WB  = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] aluop;
      logic [1:0] pc_source;
      logic       instr_done;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode
//   Purely combinational state -> control word decoder (Moore part of the FSM).
//   Ports:
//     state  in   4       current FSM state (state_t encoding)
//     ctrl   out  CTRL_W  packed ctrl_t control word, ungated
//   FETCH reports pc_write/ir_write and MEM_WR reports instr_done unconditionally;
//   the top qualifies them with mem_ready.
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [3:0]        state,
   output logic [CTRL_W-1:0] ctrl
);

   ctrl_t cw;

   // Every field defaults to 0 so IDLE and unused encodings drive nothing.
   always_comb begin
      cw = '0;
      case (state_t'(state))
         S_FETCH: begin
            cw.mem_read  = 1'b1;
            cw.alu_src_b = SRCB_FOUR;
            cw.aluop     = ALUOP_ADD;
            cw.pc_source = PCSRC_ALU;
            cw.pc_write  = 1'b1;
            cw.ir_write  = 1'b1;
         end
         S_DECODE: begin
            cw.alu_src_b = SRCB_IMM_SH2;
            cw.aluop     = ALUOP_ADD;
         end
         S_MEM_ADDR: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
            cw.aluop     = ALUOP_ADD;
         end
         S_MEM_RD: begin
            cw.mem_read = 1'b1;
            cw.i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            cw.reg_write  = 1'b1;
            cw.mem_to_reg = 1'b1;
            cw.instr_done = 1'b1;
         end
         S_MEM_WR: begin
            cw.mem_write  = 1'b1;
            cw.i_or_d     = 1'b1;
            cw.instr_done = 1'b1;
         end
         S_EXEC: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_B;
            cw.aluop     = ALUOP_FUNCT;
         end
         S_R_WB: begin
            cw.reg_write  = 1'b1;
            cw.reg_dst    = 1'b1;
            cw.instr_done = 1'b1;
         end
         S_BRANCH: begin
            cw.alu_src_a     = 1'b1;
            cw.alu_src_b     = SRCB_B;
            cw.aluop         = ALUOP_SUB;
            cw.pc_write_cond = 1'b1;
            cw.pc_source     = PCSRC_ALUOUT;
            cw.instr_done    = 1'b1;
         end
         S_JUMP: begin
            cw.pc_write   = 1'b1;
            cw.pc_source  = PCSRC_JUMP;
            cw.instr_done = 1'b1;
         end
         S_ADDI_EX: begin
            cw.alu_src_a = 1'b1;
            cw.alu_src_b = SRCB_IMM;
            cw.aluop     = ALUOP_ADD;
         end
         S_ADDI_WB: begin
            cw.reg_write  = 1'b1;
            cw.instr_done = 1'b1;
         end
         default: cw = '0;
      endcase
   end

   assign ctrl = cw;

endmodule

// File: rtl/mc_ctrl.sv
// mc_main_control
//   Main control FSM of the multi-cycle MIPS datapath: sequences fetch, decode,
//   execute, memory and writeback, and drives every datapath enable and mux select.
//   Optional feature macro: MC_CTRL_ADDI_EN (adds the ADDI_EX/ADDI_WB path for
//   opcode 001000; without it ADDI is reported as illegal).
//   Ports:
//     clk, rst_n (async active-low)   opcode (IR[31:26])   mem_ready   zero
//     pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], aluop[1:0],
//     pc_source[1:0], instr_done, illegal_op, state_o[STW-1:0]
module mc_main_control
   import mc_ctrl_pkg::*;
#(
   parameter int OPW = 6,
   parameter int STW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [OPW-1:0] opcode,
   input  logic           mem_ready,
   input  logic           zero,
   output logic           pc_write,
   output logic           pc_write_cond,
   output logic           i_or_d,
   output logic           mem_read,
   output logic           mem_write,
   output logic           ir_write,
   output logic           mem_to_reg,
   output logic           reg_dst,
   output logic           reg_write,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [1:0]     aluop,
   output logic [1:0]     pc_source,
   output logic           instr_done,
   output logic           illegal_op,
   output logic [STW-1:0] state_o
);

   state_t            state;
   state_t            next_state;
   logic [CTRL_W-1:0] ctrl_bits;
   ctrl_t             cw;

   // The branch decision (pc_write_cond & zero) is formed in the datapath's
   // PC-enable logic, so the controller only passes the flag through lint.
   logic unused_zero;
   assign unused_zero = zero;

   mc_ctrl_decode u_decode (
      .state (state),
      .ctrl  (ctrl_bits)
   );

   assign cw      = ctrl_t'(ctrl_bits);
   assign state_o = STW'(state);

   // State register; reset is asynchronous so every Moore output drops at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   // Next-state logic plus the outputs that depend on inputs as well as state:
   // the FETCH PC/IR load and the SW completion wait for mem_ready, and
   // illegal_op flags an unknown opcode during DECODE.
   always_comb begin
      next_state    = state;
      illegal_op    = 1'b0;
      pc_write      = cw.pc_write  & ((state != S_FETCH)  | mem_ready);
      ir_write      = cw.ir_write  & ((state != S_FETCH)  | mem_ready);
      instr_done    = cw.instr_done & ((state != S_MEM_WR) | mem_ready);
      pc_write_cond = cw.pc_write_cond;
      i_or_d        = cw.i_or_d;
      mem_read      = cw.mem_read;
      mem_write     = cw.mem_write;
      mem_to_reg    = cw.mem_to_reg;
      reg_dst       = cw.reg_dst;
      reg_write     = cw.reg_write;
      alu_src_a     = cw.alu_src_a;
      alu_src_b     = cw.alu_src_b;
      aluop         = cw.aluop;
      pc_source     = cw.pc_source;
      case (state)
         S_IDLE:     next_state = S_FETCH;
         S_FETCH:    if (mem_ready) next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:      next_state = S_EXEC;
               OP_LW, OP_SW:  next_state = S_MEM_ADDR;
               OP_BEQ:        next_state = S_BRANCH;
               OP_J:          next_state = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
               OP_ADDI:       next_state = S_ADDI_EX;
`endif
               default: begin
                  next_state = S_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (mem_ready) next_state = S_MEM_WB;
         S_MEM_WB:   next_state = S_FETCH;
         S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
         S_EXEC:     next_state = S_R_WB;
         S_R_WB:     next_state = S_FETCH;
         S_BRANCH:   next_state = S_FETCH;
         S_JUMP:     next_state = S_FETCH;
         S_ADDI_EX:  next_state = S_ADDI_WB;
         S_ADDI_WB:  next_state = S_FETCH;
         default:    next_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mc_main_control.sv
// tb_mc_main_control
//   Randomised instruction stream with random mem_ready stalls; a reference model
//   predicts per-instruction latency and enable activity, pushed to a scoreboard
//   and compared by a monitor on each instr_done / illegal_op pulse.
//   Directed checks cover reset, and reset asserted in the middle of a store.
module tb_mc_main_control;
   import mc_ctrl_pkg::*;

`ifdef MC_CTRL_ADDI_EN
   localparam bit ADDI_EN = 1'b1;
`else
   localparam bit ADDI_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       zero;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
   logic [1:0] alu_src_b, aluop, pc_source;
   logic [3:0] state_o;

   int checks = 0;
   int errors = 0;
   bit monOn  = 1'b0;

   typedef struct {
      int cyc; int ill; int irw; int pcw; int pcwc; int regw; int memw; int memr;
      int iord; int sub; int funct; int srcb10; int srcb11; int srca; int jsrc;
      int brsrc; int m2r; int rdst;
   } exp_t;

   exp_t expQ[$];

   mc_main_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop),
      .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Instruction class from the opcode: 0 R, 1 LW, 2 SW, 3 BEQ, 4 J, 5 ADDI, 6 illegal.
   function automatic int classify(input logic [5:0] op);
      case (op)
         6'b000000: return 0;
         6'b100011: return 1;
         6'b101011: return 2;
         6'b000100: return 3;
         6'b000010: return 4;
         6'b001000: return ADDI_EN ? 5 : 6;
         default:   return 6;
      endcase
   endfunction

   // Reference model: expected latency and activity counts for one instruction
   // with fs FETCH stall cycles and ms memory stall cycles.
   function automatic exp_t modelOf(input logic [5:0] op, input int fs, input int ms);
      exp_t e;
      e = '{default: 0};
      e.irw = 1; e.pcw = 1; e.memr = fs + 1; e.srcb11 = 1;
      case (classify(op))
         0: begin e.cyc = 4 + fs; e.regw = 1; e.funct = 1; e.srca = 1; e.rdst = 1; end
         1: begin
            e.cyc = 5 + fs + ms; e.regw = 1; e.memr += ms + 1; e.iord = ms + 1;
            e.srcb10 = 1; e.srca = 1; e.m2r = 1;
         end
         2: begin
            e.cyc = 4 + fs + ms; e.memw = ms + 1; e.iord = ms + 1; e.srcb10 = 1; e.srca = 1;
         end
         3: begin e.cyc = 3 + fs; e.pcwc = 1; e.sub = 1; e.srca = 1; e.brsrc = 1; end
         4: begin e.cyc = 3 + fs; e.pcw = 2; e.jsrc = 1; end
         5: begin e.cyc = 4 + fs; e.regw = 1; e.srcb10 = 1; e.srca = 1; end
         default: begin e.cyc = 2 + fs; e.ill = 1; end
      endcase
      return e;
   endfunction

   // One clock of stimulus: inputs applied just after a rising edge.
   task automatic drive(input logic [5:0] op, input logic mr);
      opcode    = op;
      mem_ready = mr;
      zero      = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask

   // Plays one whole instruction cycle by cycle and queues its expected result.
   task automatic applyStimulus(input logic [5:0] op, input int fs, input int ms);
      int k;
      expQ.push_back(modelOf(op, fs, ms));
      k = classify(op);
      repeat (fs) drive(6'($urandom), 1'b0);
      drive(6'($urandom), 1'b1);
      drive(op, 1'($urandom));
      case (k)
         0, 5: begin drive(op, 1'($urandom)); drive(op, 1'($urandom)); end
         1: begin
            drive(op, 1'($urandom));
            repeat (ms) drive(op, 1'b0);
            drive(op, 1'b1);
            drive(op, 1'($urandom));
         end
         2: begin
            drive(op, 1'($urandom));
            repeat (ms) drive(op, 1'b0);
            drive(op, 1'b1);
         end
         3, 4: drive(op, 1'($urandom));
         default: ;
      endcase
   endtask

   // Monitor: accumulates activity every cycle and compares against the
   // scoreboard whenever an instruction completes or is rejected.
   initial begin
      int cyc, irw, pcw, pcwc, regw, memw, memr, iord, sub, funct;
      int srcb10, srcb11, srca, jsrc, brsrc, m2r, rdst;
      exp_t e;
      cyc = 0; irw = 0; pcw = 0; pcwc = 0; regw = 0; memw = 0; memr = 0; iord = 0;
      sub = 0; funct = 0; srcb10 = 0; srcb11 = 0; srca = 0; jsrc = 0; brsrc = 0;
      m2r = 0; rdst = 0;
      forever begin
         @(negedge clk);
         if (monOn) begin
            cyc++;
            irw    += int'(ir_write);
            pcw    += int'(pc_write);
            pcwc   += int'(pc_write_cond);
            regw   += int'(reg_write);
            memw   += int'(mem_write);
            memr   += int'(mem_read);
            iord   += int'(i_or_d);
            sub    += int'(aluop == 2'b01);
            funct  += int'(aluop == 2'b10);
            srcb10 += int'(alu_src_b == 2'b10);
            srcb11 += int'(alu_src_b == 2'b11);
            srca   += int'(alu_src_a);
            jsrc   += int'(pc_write && pc_source == 2'b10);
            brsrc  += int'(pc_write_cond && pc_source == 2'b01 && aluop == 2'b01);
            if (reg_write) begin
               m2r  |= int'(mem_to_reg);
               rdst |= int'(reg_dst);
            end
            checkOutput("memReadWriteExclusive", int'(mem_read & mem_write), 0);
            if (instr_done || illegal_op) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpectedCompletion", 1, 0);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("latency",     cyc,    e.cyc);
                  checkOutput("illegalOp",   int'(illegal_op), e.ill);
                  checkOutput("instrDone",   int'(instr_done), 1 - e.ill);
                  checkOutput("irWrite",     irw,    e.irw);
                  checkOutput("pcWrite",     pcw,    e.pcw);
                  checkOutput("pcWriteCond", pcwc,   e.pcwc);
                  checkOutput("regWrite",    regw,   e.regw);
                  checkOutput("memWrite",    memw,   e.memw);
                  checkOutput("memRead",     memr,   e.memr);
                  checkOutput("iOrD",        iord,   e.iord);
                  checkOutput("aluopSub",    sub,    e.sub);
                  checkOutput("aluopFunct",  funct,  e.funct);
                  checkOutput("srcBImm",     srcb10, e.srcb10);
                  checkOutput("srcBImmSh2",  srcb11, e.srcb11);
                  checkOutput("srcA",        srca,   e.srca);
                  checkOutput("jumpSource",  jsrc,   e.jsrc);
                  checkOutput("branchSrc",   brsrc,  e.brsrc);
                  checkOutput("memToReg",    m2r,    e.m2r);
                  checkOutput("regDst",      rdst,   e.rdst);
               end
               cyc = 0; irw = 0; pcw = 0; pcwc = 0; regw = 0; memw = 0; memr = 0;
               iord = 0; sub = 0; funct = 0; srcb10 = 0; srcb11 = 0; srca = 0;
               jsrc = 0; brsrc = 0; m2r = 0; rdst = 0;
            end
         end
      end
   end

   // Watchdog so a stuck run still reports.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "[TB] timeout");
   end

   // Main stimulus sequence.
   initial begin
      logic [5:0] dirOps [8];
      int         dirFs  [8];
      int         dirMs  [8];
      logic [5:0] op;
      logic [18:0] outs;
      dirOps = '{6'b000000, 6'b100011, 6'b000100, 6'b000100, 6'b111111,
                 6'b101011, 6'b001000, 6'b000010};
      dirFs  = '{0, 2, 0, 1, 0, 0, 0, 0};
      dirMs  = '{0, 3, 0, 0, 0, 1, 0, 0};

      rst_n = 1'b0; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
              reg_dst, reg_write, alu_src_a, alu_src_b, aluop, pc_source, instr_done, illegal_op};
      checkOutput("resetOutputs", int'(outs), 0);
      checkOutput("resetState", int'(state_o), int'(S_IDLE));
      rst_n = 1'b1;
      #1;
      checkOutput("idleAfterRelease", int'(state_o), int'(S_IDLE));
      @(posedge clk);
      #1;
      checkOutput("firstFetch", int'(state_o), int'(S_FETCH));
      monOn = 1'b1;

      for (int i = 0; i < 8; i++) applyStimulus(dirOps[i], dirFs[i], dirMs[i]);
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 6))
            0: op = 6'b000000;
            1: op = 6'b100011;
            2: op = 6'b101011;
            3: op = 6'b000100;
            4: op = 6'b000010;
            5: op = 6'b001000;
            default: op = 6'($urandom);
         endcase
         applyStimulus(op, $urandom_range(0, 3), $urandom_range(0, 3));
      end
      monOn = 1'b0;
      checkOutput("scoreboardDrained", expQ.size(), 0);

      // Store interrupted by reset while waiting in MEM_WR.
      checkOutput("preStoreFetch", int'(state_o), int'(S_FETCH));
      drive(6'b101011, 1'b1);
      drive(6'b101011, 1'b0);
      drive(6'b101011, 1'b0);
      #2;
      checkOutput("storeMemWrite", int'(mem_write), 1);
      checkOutput("storeState", int'(state_o), int'(S_MEM_WR));
      rst_n = 1'b0;
      #1;
      checkOutput("resetDropsMemWrite", int'(mem_write), 0);
      checkOutput("resetDropsIOrD", int'(i_or_d), 0);
      checkOutput("resetStateIdle", int'(state_o), int'(S_IDLE));
      @(negedge clk);
      checkOutput("heldIdle", int'(state_o), int'(S_IDLE));
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("fetchAfterRelease", int'(state_o), int'(S_FETCH));
      checkOutput("fetchMemRead", int'(mem_read), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
